serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, bout set when the
// difference needed a borrow from the next bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first through one
// full-subtractor cell. Define SERIAL_SUB_SIGNED_EN to build the signed overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sub_state_e       r_state;
  sub_state_e       w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_borrow;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_accept;

  full_subtractor u_cell (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last   = (r_cnt == LAST);
  assign w_accept = (r_state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Result bits enter at the MSB, so after WIDTH steps r_res is aligned; the
  // final step bypasses r_res so diff is loaded on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_res  <= '0;
      r_cnt  <= '0;
      r_bin  <= 1'b0;
    end else if (r_state == RUN) begin
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res  <= {w_d, r_res[WIDTH-1:1]};
      r_bin  <= w_bout;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff   <= {w_d, r_res[WIDTH-1:1]};
        r_borrow <= w_bout;
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

`ifdef SERIAL_SUB_SIGNED_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // The final cell output d is the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       ovf;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] hold_diff;

`ifdef SERIAL_SUB_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called one step after an edge with the FSM in IDLE; returns in the IDLE
  // cycle following the done pulse. inj >= 0 re-asserts start (a=b=0) in that
  // RUN cycle (0-based), which must be ignored.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input int inj);
    start = 1'b1;
    a     = ia;
    b     = ib;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == inj) begin
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
      end else begin
        start = 1'b0;
      end
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("diff_hold", diff, hold_diff);
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("diff", diff, ed);
    check("borrow", borrow, eb);
    check("ovf", ovf, SIGNED_EN ? eo : 1'b0);
    hold_diff = ed;
    tick();
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("diff_kept", diff, ed);
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    hold_diff = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_ovf", ovf, 0);

    // start together with rst is ignored
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h23;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_ignored", busy, 0);
    tick();
    check("rst_start_ignored2", busy, 0);

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, -1);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, -1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, -1);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, -1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, -1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, -1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, -1);
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 2);

    // reset in the 4th RUN cycle aborts the operation
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h23;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("abort_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy0", busy, 0);
    check("abort_done0", done, 0);
    check("abort_diff0", diff, 0);
    check("abort_borrow0", borrow, 0);
    check("abort_ovf0", ovf, 0);
    hold_diff = '0;
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done", done, 0);
      tick();
    end
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, -1);

    // start held high: one operation per 10 cycles
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h01;
    for (int c = 1; c < 30; c++) begin
      tick();
      check("hold_done", done, (c % 10) == 9);
      check("hold_busy", busy, ((c % 10) >= 1) && ((c % 10) <= 8));
      if ((c % 10) == 9) check("hold_diff", diff, 8'h02);
    end
    start = 1'b0;
    tick();
    check("hold_idle", busy, 0);
    tick();
    check("hold_stopped", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
